// File: rtl/alu_multiply_sequencer.sv
// alu_multiply_sequencer
//
// Sequences the shared 16-bit ALU through shift-and-add steps to form the
// low 16 bits of an unsigned 16x16 product, with overflow detection.
// The loop ends as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; ALU inputs at idle values
// EVAL  | decide: finished (MPR==0), add (MPR[0]) or shift only
// ADD   | ALU computes ACC + MCD; result latched into ACC, flags written
// SHIFT | ALU shifts MCD left; MPR shifted right internally; OVF update
// DONE  | Product/Overflow valid, Done pulse
//
// Ports:
//   Clock        rising-edge clock, shared with the ALU
//   Reset        asynchronous active-low reset
//   Start        request pulse, sampled only in IDLE
//   Multiplicand operand M, captured when Start is accepted
//   Multiplier   operand Q, captured when Start is accepted
//   Busy         high in every state except IDLE
//   Done         one-cycle pulse in DONE
//   Product      low 16 bits of M*Q, holds until the next DONE
//   Overflow     true product exceeded 0xFFFF, holds with Product
//   AluA/AluB    ALU operand drives
//   AluFunSel    ALU function select
//   AluWF        ALU flag write enable
//   AluOut       ALU combinational result
//   AluFlags     ALU registered flags {Z,C,N,O}

module alu_multiply_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Multiplicand,
  input  logic [15:0] Multiplier,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Product,
  output logic        Overflow,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [15:0] AluOut,
  input  logic [3:0]  AluFlags
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EVAL  = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [4:0] FUN_IDLE = 5'b10000;
  localparam logic [4:0] FUN_ADD  = 5'b10100;
  localparam logic [4:0] FUN_LSL  = 5'b11011;

  logic [2:0]  state;
  logic [15:0] acc;
  logic [15:0] mcd;
  logic [15:0] mpr;
  logic        ovf;
  logic        prev_add;
  logic        carry_ovf;
  logic        shift_ovf;

  // Only the carry flag is consumed; the rest are deliberately ignored.
  logic unused_flags;
  assign unused_flags = ^{AluFlags[3], AluFlags[1:0]};

  // The ALU's carry from the ADD edge is visible during the following SHIFT;
  // prev_add keeps a stale carry from an earlier add from being misread.
  assign carry_ovf = prev_add && AluFlags[2];
  // Losing MCD[15] only matters if a later multiplier bit would add it back.
  assign shift_ovf = mcd[15] && (mpr[15:1] != 15'd0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      acc      <= 16'd0;
      mcd      <= 16'd0;
      mpr      <= 16'd0;
      ovf      <= 1'b0;
      prev_add <= 1'b0;
      Product  <= 16'd0;
      Overflow <= 1'b0;
    end else begin
      prev_add <= (state == ST_ADD);
      case (state)
        ST_IDLE: begin
          if (Start) begin
            acc   <= 16'd0;
            mcd   <= Multiplicand;
            mpr   <= Multiplier;
            ovf   <= 1'b0;
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (mpr == 16'd0) begin
            Product  <= acc;
            Overflow <= ovf;
            state    <= ST_DONE;
          end else if (mpr[0]) begin
            state <= ST_ADD;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_ADD: begin
          acc   <= AluOut;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          mcd <= AluOut;
          mpr <= {1'b0, mpr[15:1]};
          if (carry_ovf || shift_ovf) begin
            ovf <= 1'b1;
          end
          state <= ST_EVAL;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    AluA      = 16'd0;
    AluB      = 16'd0;
    AluFunSel = FUN_IDLE;
    AluWF     = 1'b0;
    case (state)
      ST_ADD: begin
        AluA      = acc;
        AluB      = mcd;
        AluFunSel = FUN_ADD;
        AluWF     = 1'b1;
      end
      ST_SHIFT: begin
        AluA      = mcd;
        AluFunSel = FUN_LSL;
      end
      default: begin
      end
    endcase
  end

  assign Busy = (state != ST_IDLE);
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_multiply_sequencer.sv
module tb_alu_multiply_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] Multiplicand;
  logic [15:0] Multiplier;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;
  logic        Overflow;
  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [15:0] AluOut;
  logic [3:0]  AluFlags;

  int checks = 0;
  int errors = 0;

  alu_multiply_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Busy         (Busy),
    .Done         (Done),
    .Product      (Product),
    .Overflow     (Overflow),
    .AluA         (AluA),
    .AluB         (AluB),
    .AluFunSel    (AluFunSel),
    .AluWF        (AluWF),
    .AluOut       (AluOut),
    .AluFlags     (AluFlags)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Simple model of the shared ALU: combinational result, registered flags.
  logic [16:0] alu_sum;
  logic [3:0]  alu_flags_next;
  always_comb begin
    alu_sum = {1'b0, AluA} + {1'b0, AluB};
    case (AluFunSel)
      5'b10100: AluOut = alu_sum[15:0];
      5'b11011: AluOut = {AluA[14:0], 1'b0};
      default:  AluOut = AluA;
    endcase
    alu_flags_next = {AluOut == 16'd0,
                      (AluFunSel == 5'b10100) ? alu_sum[16] : AluA[15],
                      AluOut[15],
                      (AluFunSel == 5'b10100) ? ((AluA[15] == AluB[15]) && (AluOut[15] != AluA[15])) : 1'b0};
  end
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) AluFlags <= 4'd0;
    else if (AluWF) AluFlags <= alu_flags_next;
  end

  // Reference model: plain arithmetic from the operation rules.
  function automatic logic [15:0] model_product(input logic [15:0] m, input logic [15:0] q);
    logic [31:0] full;
    full = {16'd0, m} * {16'd0, q};
    return full[15:0];
  endfunction

  function automatic logic model_overflow(input logic [15:0] m, input logic [15:0] q);
    logic [31:0] full;
    full = {16'd0, m} * {16'd0, q};
    return full > 32'h0000_FFFF;
  endfunction

  function automatic int model_cycles(input logic [15:0] q);
    int h;
    int p;
    h = -1;
    p = 0;
    for (int i = 0; i < 16; i++) begin
      if (q[i]) begin
        h = i;
        p++;
      end
    end
    return 2 * (h + 1) + p + 2;
  endfunction

  // Runs one operation; measures only, callers compare.
  task automatic run_op(input logic [15:0] m, input logic [15:0] q, input int repulse,
                        output int done_cyc, output int n_done, output logic busy_ok,
                        output logic [15:0] prod, output logic ovf);
    int k;
    @(negedge Clock);
    Multiplicand = m;
    Multiplier   = q;
    Start        = 1'b1;
    k        = 0;
    n_done   = 0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    prod     = 16'hDEAD;
    ovf      = 1'bx;
    while (k < 70 && (done_cyc < 0 || k < done_cyc + 3)) begin
      @(posedge Clock);
      k++;
      @(negedge Clock);
      if (k == 1) Start = 1'b0;
      if (k == repulse) Start = 1'b1;
      if (k == repulse + 1) Start = 1'b0;
      if (Done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k;
          prod     = Product;
          ovf      = Overflow;
        end
      end
      if (done_cyc < 0 || k == done_cyc) busy_ok = busy_ok & Busy;
      else busy_ok = busy_ok & !Busy;
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++;
    if (Product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", Product); end
    checks++;
    if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", Overflow); end
    checks++;
    if ({AluA, AluB, AluFunSel, AluWF} !== {16'h0, 16'h0, 5'b10000, 1'b0}) begin
      errors++;
      $display("FAIL reset_alu_idle: got A=%h B=%h F=%b WF=%b expected A=0000 B=0000 F=10000 WF=0",
               AluA, AluB, AluFunSel, AluWF);
    end
  endtask

  task automatic test_op(input string name, input logic [15:0] m, input logic [15:0] q);
    int dc, nd;
    logic bo, ov;
    logic [15:0] pr;
    run_op(m, q, -1, dc, nd, bo, pr, ov);
    checks++;
    if (dc !== model_cycles(q)) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, dc, model_cycles(q)); end
    checks++;
    if (pr !== model_product(m, q)) begin errors++; $display("FAIL %s_product: got %h expected %h", name, pr, model_product(m, q)); end
    checks++;
    if (ov !== model_overflow(m, q)) begin errors++; $display("FAIL %s_overflow: got %b expected %b", name, ov, model_overflow(m, q)); end
    checks++;
    if (bo !== 1'b1 || nd !== 1) begin errors++; $display("FAIL %s_busy_done: got busy_ok=%b dones=%0d expected 1 1", name, bo, nd); end
  endtask

  task automatic test_directed();
    test_op("m3_q5", 16'd3, 16'd5);
    test_op("q_zero", 16'h1234, 16'h0000);
    test_op("m_zero", 16'h0000, 16'h00FF);
    test_op("max_carry", 16'hFFFF, 16'hFFFF);
    test_op("shift_out", 16'h0100, 16'h0100);
    test_op("msb_only", 16'h8000, 16'h0001);
  endtask

  task automatic test_ignore_start();
    int dc, nd;
    logic bo, ov;
    logic [15:0] pr;
    run_op(16'd3, 16'd5, 3, dc, nd, bo, pr, ov);
    checks++;
    if (nd !== 1 || dc !== 10) begin errors++; $display("FAIL ignore_start_done: got dones=%0d at %0d expected 1 at 10", nd, dc); end
    checks++;
    if (pr !== 16'h000F || bo !== 1'b1) begin errors++; $display("FAIL ignore_start_product: got %h busy_ok=%b expected 000f 1", pr, bo); end
  endtask

  task automatic test_alu_drive();
    @(negedge Clock);
    Multiplicand = 16'h1357;
    Multiplier   = 16'h0001;
    Start        = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    checks++;
    if ({AluFunSel, AluWF} !== {5'b10000, 1'b0}) begin errors++; $display("FAIL drive_eval: got F=%b WF=%b expected 10000 0", AluFunSel, AluWF); end
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({AluA, AluB, AluFunSel, AluWF} !== {16'h0000, 16'h1357, 5'b10100, 1'b1}) begin
      errors++;
      $display("FAIL drive_add: got A=%h B=%h F=%b WF=%b expected 0000 1357 10100 1", AluA, AluB, AluFunSel, AluWF);
    end
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({AluA, AluFunSel, AluWF} !== {16'h1357, 5'b11011, 1'b0}) begin
      errors++;
      $display("FAIL drive_shift: got A=%h F=%b WF=%b expected 1357 11011 0", AluA, AluFunSel, AluWF);
    end
    repeat (3) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_random();
    logic [15:0] m, q;
    for (int i = 0; i < 25; i++) begin
      m = 16'($urandom) >> $urandom_range(0, 15);
      q = 16'($urandom) >> $urandom_range(0, 15);
      test_op("random", m, q);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic got;
    @(negedge Clock);
    Multiplicand = 16'd9;
    Multiplier   = 16'd2;
    Start        = 1'b1;
    k   = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge Clock);
      k++;
      @(negedge Clock);
      if (Done) got = 1'b1;
    end
    checks++;
    if (!got || k !== model_cycles(16'd2) || Product !== 16'h0012) begin
      errors++;
      $display("FAIL b2b_first: got done=%b at %0d product %h expected done at %0d product 0012", got, k, Product, model_cycles(16'd2));
    end
    Multiplicand = 16'd7;
    Multiplier   = 16'd6;
    @(posedge Clock);
    @(negedge Clock);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b expected 0", Busy); end
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b expected 1", Busy); end
    k   = 1;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge Clock);
      k++;
      @(negedge Clock);
      if (Done) got = 1'b1;
    end
    checks++;
    if (!got || k !== model_cycles(16'd6) || Product !== 16'h002A) begin
      errors++;
      $display("FAIL b2b_second: got done=%b at %0d product %h expected done at %0d product 002a", got, k, Product, model_cycles(16'd6));
    end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    int dc, nd;
    logic bo, ov;
    logic [15:0] pr;
    @(negedge Clock);
    Multiplicand = 16'hFFFF;
    Multiplier   = 16'hFFFF;
    Start        = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midreset_busy: got busy=%b done=%b expected 0 0", Busy, Done); end
    checks++;
    if (Product !== 16'h0000 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got product %h overflow %b expected 0000 0", Product, Overflow);
    end
    @(negedge Clock);
    Reset = 1'b1;
    run_op(16'd7, 16'd6, -1, dc, nd, bo, pr, ov);
    checks++;
    if (pr !== 16'h002A || ov !== 1'b0 || dc !== 10 || nd !== 1) begin
      errors++;
      $display("FAIL midreset_rerun: got product %h ovf %b done at %0d x%0d expected 002a 0 at 10 x1", pr, ov, dc, nd);
    end
  endtask

  initial begin
    Reset        = 1'b0;
    Start        = 1'b0;
    Multiplicand = 16'd0;
    Multiplier   = 16'd0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    test_reset();
    Reset = 1'b1;
    test_directed();
    test_ignore_start();
    test_alu_drive();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
